// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex segment
// codes (bit 6 = g .. bit 0 = a), blanking patterns and the digit limit.
package seg7_pkg;

  localparam int MAX_DIGITS  = 8;
  localparam int DIGIT_IDX_W = 3;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t      SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  localparam seg_t SEG_HEX_0 = 7'h40;
  localparam seg_t SEG_HEX_1 = 7'h79;
  localparam seg_t SEG_HEX_2 = 7'h24;
  localparam seg_t SEG_HEX_3 = 7'h30;
  localparam seg_t SEG_HEX_4 = 7'h19;
  localparam seg_t SEG_HEX_5 = 7'h12;
  localparam seg_t SEG_HEX_6 = 7'h02;
  localparam seg_t SEG_HEX_7 = 7'h78;
  localparam seg_t SEG_HEX_8 = 7'h00;
  localparam seg_t SEG_HEX_9 = 7'h10;
  localparam seg_t SEG_HEX_A = 7'h08;
  localparam seg_t SEG_HEX_B = 7'h03;
  localparam seg_t SEG_HEX_C = 7'h46;
  localparam seg_t SEG_HEX_D = 7'h21;
  localparam seg_t SEG_HEX_E = 7'h06;
  localparam seg_t SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_driver_hex7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Nibble to segment lookup
  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'h0:    segments = SEG_HEX_0;
      4'h1:    segments = SEG_HEX_1;
      4'h2:    segments = SEG_HEX_2;
      4'h3:    segments = SEG_HEX_3;
      4'h4:    segments = SEG_HEX_4;
      4'h5:    segments = SEG_HEX_5;
      4'h6:    segments = SEG_HEX_6;
      4'h7:    segments = SEG_HEX_7;
      4'h8:    segments = SEG_HEX_8;
      4'h9:    segments = SEG_HEX_9;
      4'hA:    segments = SEG_HEX_A;
      4'hB:    segments = SEG_HEX_B;
      4'hC:    segments = SEG_HEX_C;
      4'hD:    segments = SEG_HEX_D;
      4'hE:    segments = SEG_HEX_E;
      4'hF:    segments = SEG_HEX_F;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment driver with per-frame snapshot of value.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        enable,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIGIT_IDX_W-1:0] IDX_LAST = DIGIT_IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]       refresh_cnt;
  logic [DIGIT_IDX_W-1:0] digit_idx;
  logic [31:0]            shadow;
  logic                   tick;
  logic                   frame_wrap;
  logic [3:0]             cur_nibble;
  logic [6:0]             cur_segments;
  logic                   blank;

  assign tick       = (refresh_cnt == CNT_LAST);
  assign frame_wrap = tick && (digit_idx == IDX_LAST);
  assign cur_nibble = shadow[{digit_idx, 2'b00} +: 4];

  hex7_decode u_hex7_decode (
    .nibble   (cur_nibble),
    .segments (cur_segments)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [MAX_DIGITS:0] upper_zero;

  // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 of the snapshot are all zero
  always_comb begin
    upper_zero             = '0;
    upper_zero[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (shadow[4*i +: 4] == 4'h0);
    end
  end

  assign blank = (digit_idx != {DIGIT_IDX_W{1'b0}}) && upper_zero[digit_idx];
`else
  assign blank = 1'b0;
`endif

  // Refresh timer, digit scan and frame-boundary snapshot; enable never stalls these
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt <= {CNT_W{1'b0}};
      digit_idx   <= {DIGIT_IDX_W{1'b0}};
      shadow      <= 32'h0000_0000;
    end else begin
      if (tick) begin
        refresh_cnt <= {CNT_W{1'b0}};
        if (digit_idx == IDX_LAST) begin
          digit_idx <= {DIGIT_IDX_W{1'b0}};
        end else begin
          digit_idx <= digit_idx + {{(DIGIT_IDX_W-1){1'b0}}, 1'b1};
        end
      end else begin
        refresh_cnt <= refresh_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (frame_wrap) begin
        shadow <= value;
      end else begin
        shadow <= shadow;
      end
    end
  end

  // Registered anode/cathode drive; a single anode is low only when lit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (enable && !blank) begin
        an  <= ~(8'b0000_0001 << digit_idx);
        seg <= cur_segments;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule
